elevator_call_scheduler: RTL and testbench
==========================================

// Module: elevator_call_scheduler
// PURPOSE
// - Sequences the 3-floor elevator FSM: latches hall/cab calls, chooses the next target floor (SCAN),
//   drives door-closed (P) and target floor to the elevator FSM, times door dwell, flags faults.
// - Sits between call buttons and the elevator FSM; its floor input is the FSM's EA output.
// PARAMETERS
// T_CLOSE    4   cycles door_closed held with target = current floor before travel starts
// T_DOOR     8   door-open dwell cycles after arrival
// T_TIMEOUT  32  max TRAVEL cycles before FAULT
// CNT_W      6   timer width; must hold max(T_CLOSE,T_DOOR,T_TIMEOUT)
// PORTS
// clk          in   1  clock, rising edge
// rst          in   1  asynchronous reset, active-high
// call         in   3  level call requests, bit i = floor i+1
// door_hold    in   1  held-open request, honoured only in DOOR_OPEN
// cur_floor    in   2  current floor from elevator FSM: 00=F1, 01=F2, 10=F3, 11=invalid
// door_closed  out  1  P to elevator FSM (1 = closed, motion allowed)
// tgt_floor    out  2  requested floor to elevator FSM, same encoding as cur_floor
// motor        out  2  00 stop, 01 up, 10 down
// pending      out  3  latched outstanding calls
// busy         out  1  state != IDLE
// fault        out  1  sticky fault indication
// BEHAVIOUR
// - Reset (async, immediate, also mid-travel): state IDLE, pending=000, dir=UP, tgt_floor=00,
//   door_closed=0, motor=00, fault=0, timer=0.
// - pending[i] set by call[i]=1 on any clock edge; cleared on entry to DOOR_OPEN at floor i.
//   Set and clear in the same cycle: clear wins. call at cur_floor while in DOOR_OPEN: no set, dwell restarts.
// - SCAN select (combinational on pending, cur_floor, dir): nearest pending floor strictly ahead in dir;
//   none ahead -> nearest behind, dir flips when the target is latched; none -> no target.
// - States:
//   IDLE: door_closed=0, tgt=cur, motor=00. pending[cur] -> DOOR_OPEN; other pending -> CLOSE, timer=T_CLOSE.
//   CLOSE: door_closed=1, tgt=cur. Timer hits 0 -> latch SCAN target, -> TRAVEL, timer=T_TIMEOUT.
//     Calls arriving in CLOSE are merged; target chosen at the exit cycle.
//   TRAVEL: door_closed=1, tgt=latched target, motor=01 if tgt>cur, 10 if tgt<cur. Target not re-evaluated.
//     cur==tgt -> DOOR_OPEN (motor=00 same cycle as the transition's registered outputs).
//     Timer hits 0 -> FAULT.
//   DOOR_OPEN: door_closed=0, motor=00, tgt=cur, timer=T_DOOR on entry; door_hold or call[cur] reloads it.
//     Timer hits 0 -> IDLE.
//   FAULT: fault=1, door_closed=0, motor=00, tgt=cur; calls still latch; exit only via rst.
// - cur_floor=11 in any state -> FAULT next cycle.
// - All outputs registered; state change visible one cycle after the deciding edge.
// - Timers are down-counters, saturate at 0; loaded values are used unchanged (T=0 behaves as T=1).
// STRUCTURE
// - elevator_pkg: floor codes (F1/F2/F3/F_INV), motor codes (STOP/UP/DOWN), scheduler state enum,
//   dir constants. This package is shared with the elevator FSM.
// - Sub-module sched_timer: loadable CNT_W down-counter with load, value and zero flag.
//   One instance, reused by CLOSE, TRAVEL and DOOR_OPEN.
// - SCAN select stays inline as a combinational function.
// TESTING
// 1 rst during TRAVEL -> all outputs at reset values in the same cycle, pending=000.
// 2 cur=F1, pulse call=100 -> CLOSE 4 cycles with tgt=00; then TRAVEL tgt=10, motor=01;
//   drive cur=10 -> DOOR_OPEN, pending=000, 8 cycles of door_closed=0, then IDLE.
// 3 cur=F2, dir=UP, call=101 together -> target F3 first (motor=01),
//   then F1 with dir flipped (motor=10).
// 4 IDLE at F2, call=010 -> DOOR_OPEN directly, door_closed stays 0.
//   door_hold held 20 cycles -> stays open for 20+8 cycles.
// 5 TRAVEL with cur held fixed for 32 cycles -> fault=1, motor=00; persists until rst.
// 6 cur_floor=11 in IDLE -> fault=1 next cycle; a new call sets pending but causes no motion.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator FSM and its call scheduler:
// floor/motor codes, scheduler states, travel-direction constants and timing.
package elevator_pkg;

    localparam int T_CLOSE   = 4;
    localparam int T_DOOR    = 8;
    localparam int T_TIMEOUT = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        F1    = 2'b00,
        F2    = 2'b01,
        F3    = 2'b10,
        F_INV = 2'b11
    } floor_e;

    typedef enum logic [1:0] {
        MOT_STOP = 2'b00,
        MOT_UP   = 2'b01,
        MOT_DOWN = 2'b10
    } motor_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLOSE,
        S_TRAVEL,
        S_DOOR_OPEN,
        S_FAULT
    } sched_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/elevator_call_scheduler_timer.sv
// Loadable saturating down-counter shared by the CLOSE, TRAVEL and DOOR_OPEN phases.
module sched_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN call scheduler for the 3-floor elevator: latches calls, picks targets,
// times door close/dwell and travel, and reports sticky faults.
module elevator_call_scheduler
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] call_i,
    input  logic       door_hold_i,
    input  logic [1:0] cur_floor_i,
    output logic       door_closed_o,
    output logic [1:0] tgt_floor_o,
    output logic [1:0] motor_o,
    output logic [2:0] pending_o,
    output logic       busy_o,
    output logic       fault_o
);

    typedef struct packed {
        logic       valid;
        logic [1:0] floor;
        logic       dir;
    } scan_t;

    // Nearest pending floor strictly ahead; otherwise nearest behind with the direction reversed.
    function automatic scan_t scan_select(input logic [2:0] pend, input logic [1:0] cur,
                                          input logic dir);
        scan_t r;
        r.valid = 1'b0;
        r.floor = 2'b00;
        r.dir   = dir;
        if (dir == DIR_UP) begin
            for (int f = 2; f >= 0; f--) begin
                if (pend[f] && f > int'(cur)) begin
                    r.valid = 1'b1;
                    r.floor = 2'(f);
                end
            end
            if (!r.valid) begin
                for (int f = 0; f <= 2; f++) begin
                    if (pend[f] && f < int'(cur)) begin
                        r.valid = 1'b1;
                        r.floor = 2'(f);
                        r.dir   = DIR_DOWN;
                    end
                end
            end
        end else begin
            for (int f = 0; f <= 2; f++) begin
                if (pend[f] && f < int'(cur)) begin
                    r.valid = 1'b1;
                    r.floor = 2'(f);
                end
            end
            if (!r.valid) begin
                for (int f = 2; f >= 0; f--) begin
                    if (pend[f] && f > int'(cur)) begin
                        r.valid = 1'b1;
                        r.floor = 2'(f);
                        r.dir   = DIR_UP;
                    end
                end
            end
        end
        return r;
    endfunction

    sched_state_e     state_q, state_d;
    logic [2:0]       pending_q, pending_d;
    logic             dir_q, dir_d;
    logic [1:0]       target_q, target_d;
    logic             door_closed_q, door_closed_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [1:0]       motor_q, motor_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;
    logic             tmr_expire;
    logic [2:0]       cur_mask;
    scan_t            scan;

    sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .value_o    (tmr_value),
        .zero_o     (tmr_zero)
    );

    // A loaded value T spans exactly T cycles in the state; a loaded 0 acts like 1.
    assign tmr_expire = tmr_zero || (tmr_value == CNT_W'(1));
    assign cur_mask   = (cur_floor_i == F_INV) ? 3'b000 : (3'b001 << cur_floor_i);
    assign scan       = scan_select(pending_q, cur_floor_i, dir_q);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | call_i;
        dir_d     = dir_q;
        target_d  = target_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        if (cur_floor_i == F_INV) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|(pending_q & cur_mask)) begin
                        state_d  = S_DOOR_OPEN;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_DOOR);
                    end else if (|pending_q) begin
                        state_d  = S_CLOSE;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_CLOSE);
                    end
                end
                S_CLOSE: begin
                    if (tmr_expire) begin
                        if (scan.valid) begin
                            state_d  = S_TRAVEL;
                            target_d = scan.floor;
                            dir_d    = scan.dir;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(T_TIMEOUT);
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_TRAVEL: begin
                    if (cur_floor_i == target_q) begin
                        state_d  = S_DOOR_OPEN;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_DOOR);
                    end else if (tmr_expire) begin
                        state_d = S_FAULT;
                    end
                end
                S_DOOR_OPEN: begin
                    if (door_hold_i || |(call_i & cur_mask)) begin
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(T_DOOR);
                    end else if (tmr_expire) begin
                        state_d = S_IDLE;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FAULT;
                end
            endcase
        end
        // The floor being served with its door open is never left pending.
        if (state_q == S_DOOR_OPEN || state_d == S_DOOR_OPEN) begin
            pending_d = pending_d & ~cur_mask;
        end
    end

    always_comb begin
        door_closed_d = (state_d == S_CLOSE) || (state_d == S_TRAVEL);
        tgt_d         = (state_d == S_TRAVEL) ? target_d : cur_floor_i;
        motor_d       = MOT_STOP;
        if (state_d == S_TRAVEL) begin
            if (target_d > cur_floor_i) begin
                motor_d = MOT_UP;
            end else if (target_d < cur_floor_i) begin
                motor_d = MOT_DOWN;
            end
        end
        busy_d  = (state_d != S_IDLE);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pending_q     <= 3'b000;
            dir_q         <= DIR_UP;
            target_q      <= F1;
            door_closed_q <= 1'b0;
            tgt_q         <= F1;
            motor_q       <= MOT_STOP;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            dir_q         <= dir_d;
            target_q      <= target_d;
            door_closed_q <= door_closed_d;
            tgt_q         <= tgt_d;
            motor_q       <= motor_d;
            busy_q        <= busy_d;
            fault_q       <= fault_d;
        end
    end

    assign door_closed_o = door_closed_q;
    assign tgt_floor_o   = tgt_q;
    assign motor_o       = motor_q;
    assign pending_o     = pending_q;
    assign busy_o        = busy_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed scenarios plus
// randomized traffic against a phase-level behavioural model of the scheduler.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] callI = 3'b000;
    logic       holdI = 1'b0;
    logic [1:0] curI = 2'b00;

    logic       door_closed_o;
    logic [1:0] tgt_floor_o;
    logic [1:0] motor_o;
    logic [2:0] pending_o;
    logic       busy_o;
    logic       fault_o;

    int errors = 0;
    int checks = 0;

    elevator_call_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .call_i        (callI),
        .door_hold_i   (holdI),
        .cur_floor_i   (curI),
        .door_closed_o (door_closed_o),
        .tgt_floor_o   (tgt_floor_o),
        .motor_o       (motor_o),
        .pending_o     (pending_o),
        .busy_o        (busy_o),
        .fault_o       (fault_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase plus cycles left in it, pending set, direction and goal floor.
    typedef enum int {P_IDLE, P_CLOSE, P_TRAVEL, P_DOOR, P_FAULT} phase_e;
    phase_e mPhase = P_IDLE;
    bit [2:0] mPend = 3'b000;
    int mDir = 1;
    int mGoal = 0;
    int mLeft = 0;
    int mDc = 0, mTgt = 0, mMot = 0, mBusy = 0, mFault = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = P_IDLE;
        mPend  = 3'b000;
        mDir   = 1;
        mGoal  = 0;
        mLeft  = 0;
        mDc    = 0;
        mTgt   = 0;
        mMot   = 0;
        mBusy  = 0;
        mFault = 0;
    endtask

    task automatic modelStep(input bit [2:0] c, input bit h, input int cur);
        phase_e nxt;
        bit [2:0] np;
        int found;
        nxt = mPhase;
        np = mPend | c;
        found = -1;
        if (cur == 3) begin
            nxt = P_FAULT;
        end else begin
            case (mPhase)
                P_IDLE: begin
                    if (mPend[cur]) begin
                        nxt = P_DOOR;
                        mLeft = 8;
                    end else if (mPend != 3'b000) begin
                        nxt = P_CLOSE;
                        mLeft = 4;
                    end
                end
                P_CLOSE: begin
                    mLeft--;
                    if (mLeft <= 0) begin
                        if (mDir > 0) begin
                            for (int f = cur + 1; f <= 2 && found < 0; f++) if (mPend[f]) found = f;
                            if (found < 0) begin
                                for (int f = cur - 1; f >= 0 && found < 0; f--) if (mPend[f]) found = f;
                                if (found >= 0) mDir = -1;
                            end
                        end else begin
                            for (int f = cur - 1; f >= 0 && found < 0; f--) if (mPend[f]) found = f;
                            if (found < 0) begin
                                for (int f = cur + 1; f <= 2 && found < 0; f++) if (mPend[f]) found = f;
                                if (found >= 0) mDir = 1;
                            end
                        end
                        if (found >= 0) begin
                            mGoal = found;
                            nxt = P_TRAVEL;
                            mLeft = 32;
                        end else begin
                            nxt = P_IDLE;
                        end
                    end
                end
                P_TRAVEL: begin
                    if (cur == mGoal) begin
                        nxt = P_DOOR;
                        mLeft = 8;
                    end else begin
                        mLeft--;
                        if (mLeft <= 0) nxt = P_FAULT;
                    end
                end
                P_DOOR: begin
                    if (h || c[cur]) begin
                        mLeft = 8;
                    end else begin
                        mLeft--;
                        if (mLeft <= 0) nxt = P_IDLE;
                    end
                end
                default: begin
                end
            endcase
            if (mPhase == P_DOOR || nxt == P_DOOR) np[cur] = 1'b0;
        end
        mPhase = nxt;
        mPend  = np;
        mDc    = (nxt == P_CLOSE || nxt == P_TRAVEL) ? 1 : 0;
        mTgt   = (nxt == P_TRAVEL) ? mGoal : cur;
        mMot   = (nxt != P_TRAVEL) ? 0 : (mGoal > cur) ? 1 : (mGoal < cur) ? 2 : 0;
        mBusy  = (nxt != P_IDLE) ? 1 : 0;
        mFault = (nxt == P_FAULT) ? 1 : 0;
    endtask

    always @(posedge rst) modelReset();

    // Every cycle: advance the model on the inputs seen at this edge, then compare all outputs.
    always @(posedge clk) begin
        if (rst) modelReset();
        else modelStep(callI, holdI, int'(curI));
        #1;
        checkOutput("door_closed", int'(door_closed_o), mDc);
        checkOutput("tgt_floor", int'(tgt_floor_o), mTgt);
        checkOutput("motor", int'(motor_o), mMot);
        checkOutput("pending", int'(pending_o), int'(mPend));
        checkOutput("busy", int'(busy_o), mBusy);
        checkOutput("fault", int'(fault_o), mFault);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic h, input logic [1:0] f);
        callI = c;
        holdI = h;
        curI  = f;
    endtask

    task automatic resetDut(input logic [1:0] f);
        applyStimulus(3'b000, 1'b0, f);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int found;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset during TRAVEL takes effect immediately.
        resetDut(2'b00);
        applyStimulus(3'b100, 1'b0, 2'b00);
        tick();
        applyStimulus(3'b000, 1'b0, 2'b00);
        repeat (8) tick();
        checkOutput("t1_in_travel", int'(motor_o), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_rst_door", int'(door_closed_o), 0);
        checkOutput("t1_rst_tgt", int'(tgt_floor_o), 0);
        checkOutput("t1_rst_motor", int'(motor_o), 0);
        checkOutput("t1_rst_pending", int'(pending_o), 0);
        checkOutput("t1_rst_busy", int'(busy_o), 0);
        checkOutput("t1_rst_fault", int'(fault_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // F1 -> F3 trip: 4 close cycles, travel, 8 dwell cycles, back to idle.
        resetDut(2'b00);
        applyStimulus(3'b100, 1'b0, 2'b00);
        tick();
        checkOutput("t2_pending_latched", int'(pending_o), 4);
        checkOutput("t2_still_idle", int'(busy_o), 0);
        applyStimulus(3'b000, 1'b0, 2'b00);
        tick();
        checkOutput("t2_close_door", int'(door_closed_o), 1);
        checkOutput("t2_close_tgt", int'(tgt_floor_o), 0);
        repeat (3) tick();
        checkOutput("t2_close_last_motor", int'(motor_o), 0);
        checkOutput("t2_close_last_tgt", int'(tgt_floor_o), 0);
        tick();
        checkOutput("t2_travel_tgt", int'(tgt_floor_o), 2);
        checkOutput("t2_travel_motor", int'(motor_o), 1);
        applyStimulus(3'b000, 1'b0, 2'b10);
        tick();
        checkOutput("t2_open_door", int'(door_closed_o), 0);
        checkOutput("t2_open_pending", int'(pending_o), 0);
        checkOutput("t2_open_motor", int'(motor_o), 0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy_o) break;
            n++;
        end
        checkOutput("t2_dwell_cycles", n, 8);

        // SCAN from F2 going up: F3 first, then F1 with direction reversed.
        resetDut(2'b01);
        applyStimulus(3'b101, 1'b0, 2'b01);
        tick();
        applyStimulus(3'b000, 1'b0, 2'b01);
        repeat (5) tick();
        checkOutput("t3_first_tgt", int'(tgt_floor_o), 2);
        checkOutput("t3_first_motor", int'(motor_o), 1);
        applyStimulus(3'b000, 1'b0, 2'b10);
        found = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (door_closed_o) begin
                found = 1;
                break;
            end
        end
        checkOutput("t3_second_close_seen", found, 1);
        repeat (4) tick();
        checkOutput("t3_second_tgt", int'(tgt_floor_o), 0);
        checkOutput("t3_second_motor", int'(motor_o), 2);
        checkOutput("t3_second_pending", int'(pending_o), 1);
        applyStimulus(3'b000, 1'b0, 2'b00);
        repeat (12) tick();

        // Call at the current floor opens the door directly; door_hold extends the dwell.
        resetDut(2'b01);
        applyStimulus(3'b010, 1'b0, 2'b01);
        tick();
        applyStimulus(3'b000, 1'b0, 2'b01);
        tick();
        checkOutput("t4_open_busy", int'(busy_o), 1);
        checkOutput("t4_open_door", int'(door_closed_o), 0);
        checkOutput("t4_open_pending", int'(pending_o), 0);
        applyStimulus(3'b000, 1'b1, 2'b01);
        repeat (20) tick();
        applyStimulus(3'b000, 1'b0, 2'b01);
        n = 21;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!busy_o) break;
            n++;
        end
        checkOutput("t4_held_open_cycles", n, 28);

        // Travel timeout: floor never changes, fault after 32 travel cycles and stays.
        resetDut(2'b00);
        applyStimulus(3'b010, 1'b0, 2'b00);
        tick();
        applyStimulus(3'b000, 1'b0, 2'b00);
        repeat (5) tick();
        checkOutput("t5_travel_motor", int'(motor_o), 1);
        checkOutput("t5_travel_tgt", int'(tgt_floor_o), 1);
        n = 0;
        while (!fault_o && n < 60) begin
            tick();
            n++;
        end
        checkOutput("t5_timeout_cycles", n, 32);
        checkOutput("t5_fault_motor", int'(motor_o), 0);
        checkOutput("t5_fault_door", int'(door_closed_o), 0);
        repeat (6) tick();
        checkOutput("t5_fault_sticky", int'(fault_o), 1);

        // Invalid floor code faults on the next cycle; calls latch but cause no motion.
        resetDut(2'b00);
        applyStimulus(3'b000, 1'b0, 2'b11);
        tick();
        checkOutput("t6_fault", int'(fault_o), 1);
        applyStimulus(3'b100, 1'b0, 2'b11);
        tick();
        checkOutput("t6_pending", int'(pending_o), 4);
        applyStimulus(3'b000, 1'b0, 2'b11);
        repeat (5) tick();
        checkOutput("t6_no_motion", int'(motor_o), 0);
        checkOutput("t6_door_open", int'(door_closed_o), 0);

        // Randomized traffic with a simple plant that follows the model's motor command.
        for (int seg = 0; seg < 16; seg++) begin
            int stall;
            int invAt;
            int moveCnt;
            int moveDelay;
            logic [1:0] cur;
            logic [2:0] c;
            logic h;
            stall = ($urandom_range(0, 4) == 0) ? 1 : 0;
            invAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 200)) : -1;
            cur = 2'($urandom_range(0, 2));
            resetDut(cur);
            moveCnt = 0;
            moveDelay = int'($urandom_range(1, 6));
            for (int cyc = 0; cyc < 250; cyc++) begin
                c = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                h = ($urandom_range(0, 11) == 0);
                if (cyc == invAt) begin
                    cur = 2'b11;
                end else if (cur != 2'b11 && mMot != 0 && stall == 0) begin
                    moveCnt++;
                    if (moveCnt >= moveDelay) begin
                        cur = (mMot == 1) ? cur + 2'b01 : cur - 2'b01;
                        moveCnt = 0;
                        moveDelay = int'($urandom_range(1, 6));
                    end
                end else begin
                    moveCnt = 0;
                end
                applyStimulus(c, h, cur);
                tick();
            end
        end

        applyStimulus(3'b000, 1'b0, 2'b00);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
